// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state, mode and clock constants for the interval timer
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  localparam int CLK_HZ_DEFAULT = 50_000_000;

endpackage

// File: rtl/timer_interval.sv
// rtl/timer_interval.sv - programmable interval timer with periodic and one-shot modes
module timer_interval
  import timer_pkg::*;
#(
  parameter int WIDTH          = 28,
  parameter int DEFAULT_PERIOD = CLK_HZ_DEFAULT,
  parameter int AUTO_START     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] period_in,
  output logic             rollover,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE          = WIDTH'(1);
  localparam logic [WIDTH-1:0] RESET_PERIOD = WIDTH'(DEFAULT_PERIOD);
  localparam logic             AUTO         = (AUTO_START != 0);

  state_t           state;
  logic [WIDTH-1:0] period;
  logic             mode_q;
  logic             wrap;

  // >= rather than == so a period shrunk below the live count wraps on the next advance
  assign wrap = (count >= period - ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= AUTO ? RUN : IDLE;
      running  <= AUTO;
      count    <= '0;
      rollover <= 1'b0;
      done     <= 1'b0;
      period   <= RESET_PERIOD;
      mode_q   <= MODE_PERIODIC;
    end else begin
      rollover <= 1'b0;
      if (load) begin
        period <= (period_in == '0) ? ONE : period_in;
      end

      if (stop) begin
        state   <= IDLE;
        running <= 1'b0;
        done    <= 1'b0;
        count   <= '0;
      end else if (start) begin
        state   <= RUN;
        running <= 1'b1;
        done    <= 1'b0;
        count   <= '0;
        mode_q  <= mode;
      end else begin
        case (state)
          RUN: begin
            if (enable) begin
              if (wrap) begin
                count    <= '0;
                rollover <= 1'b1;
                if (mode_q == MODE_ONESHOT) begin
                  state   <= DONE;
                  running <= 1'b0;
                  done    <= 1'b1;
                end
              end else begin
                count <= count + ONE;
              end
            end
          end
          default: count <= '0;
        endcase
      end
    end
  end

endmodule
